// File: rtl/serial_pattern_detect.sv
// Serial bit-pattern detector with a runtime-programmable pattern and length.
// Overlapping or non-overlapping matches, match pulse and saturating counter.
module serial_pattern_detect #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W = 8,
  localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               bitin,
  input  logic               bit_valid,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
  input  logic               clear,
  output logic               indicator,
  output logic               match_pulse,
  output logic [CNT_W-1:0]   match_count
);

  // The oldest history bit only ever feeds the shifted view, so it is not kept.
  logic [MAX_LEN-2:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] nh;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [LEN_W-1:0]   fill_inc;
  logic               ind_q, ind_d;
  logic               pulse_q, pulse_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               len_ok;
  logic               fill_ok;
  logic               pat_eq;
  logic               hit;
  logic               cnt_max;

  assign nh = {hist_q, bitin};

  for (genvar g = 0; g < MAX_LEN; g++) begin : g_mask
    assign len_mask[g] = (32'(pat_len) > 32'(g));
  end

  assign len_ok = (pat_len != '0) &&
                  (32'(pat_len) <= 32'(MAX_LEN));

  assign fill_ok = (32'(fill_q) + 32'd1) >= 32'(pat_len);

  assign pat_eq = ((nh ^ pattern) & len_mask) == '0;

  assign hit = bit_valid & len_ok & fill_ok & pat_eq;

  assign fill_inc = (32'(fill_q) >= 32'(MAX_LEN)) ?
                    fill_q : fill_q + LEN_W'(1);

  assign cnt_max = (cnt_q == {CNT_W{1'b1}});

  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    ind_d   = ind_q;
    pulse_d = 1'b0;
    cnt_d   = cnt_q;
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
      ind_d  = 1'b0;
      cnt_d  = '0;
    end else if (bit_valid) begin
      hist_d  = nh[MAX_LEN-2:0];
      ind_d   = hit;
      pulse_d = hit;
      // Non-overlapping: bits of a match may not start the next one.
      fill_d  = (hit && !overlap) ? '0 : fill_inc;
      if (hit && !cnt_max) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hist_q  <= '0;
      fill_q  <= '0;
      ind_q   <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      ind_q   <= ind_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign indicator   = ind_q;
  assign match_pulse = pulse_q;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_serial_pattern_detect.sv
// Bench for serial_pattern_detect: directed scenarios plus random stream,
// both checked against a queue-based reference model.
module tb_serial_pattern_detect;

  localparam int ML = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          bitin = 1'b0;
  logic          bit_valid = 1'b0;
  logic [ML-1:0] pattern = '0;
  logic [3:0]    pat_len = 4'd3;
  logic          overlap = 1'b1;
  logic          clear = 1'b0;

  logic       ind8, pulse8;
  logic [7:0] cnt8;
  logic       ind2, pulse2;
  logic [1:0] cnt2;

  int n_tests = 0;
  int n_fail = 0;

  bit hq[$];
  int m_fill;
  bit m_ind, m_pulse;
  int m_cnt8, m_cnt2;

  serial_pattern_detect #(.MAX_LEN(ML), .CNT_W(8)) u_dut (
    .clock(clock), .reset(reset), .bitin(bitin),
    .bit_valid(bit_valid), .pattern(pattern),
    .pat_len(pat_len), .overlap(overlap), .clear(clear),
    .indicator(ind8), .match_pulse(pulse8),
    .match_count(cnt8)
  );

  serial_pattern_detect #(.MAX_LEN(ML), .CNT_W(2)) u_sat (
    .clock(clock), .reset(reset), .bitin(bitin),
    .bit_valid(bit_valid), .pattern(pattern),
    .pat_len(pat_len), .overlap(overlap), .clear(clear),
    .indicator(ind2), .match_pulse(pulse2),
    .match_count(cnt2)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    hq.delete();
    m_fill = 0;
    m_ind = 0;
    m_pulse = 0;
    m_cnt8 = 0;
    m_cnt2 = 0;
  endtask

  task automatic model_edge();
    int len;
    bit m;
    len = int'(pat_len);
    m = 0;
    if (clear) begin
      model_reset();
    end else if (bit_valid) begin
      hq.push_back(bitin);
      if (hq.size() > 64) void'(hq.pop_front());
      if (len >= 1 && len <= ML && m_fill + 1 >= len) begin
        m = 1;
        for (int k = 0; k < len; k++)
          if (hq[hq.size() - 1 - k] != pattern[k]) m = 0;
      end
      m_ind = m;
      m_pulse = m;
      if (m) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (m && !overlap) m_fill = 0;
      else if (m_fill < ML) m_fill++;
    end else begin
      m_pulse = 0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_ind"}, 32'(ind8), 32'(m_ind));
    chk({tag, "_pulse"}, 32'(pulse8), 32'(m_pulse));
    chk({tag, "_cnt"}, 32'(cnt8), 32'(m_cnt8));
    chk({tag, "_ind2"}, 32'(ind2), 32'(m_ind));
    chk({tag, "_cnt2"}, 32'(cnt2), 32'(m_cnt2));
  endtask

  task automatic cyc(input logic b, input logic v, input logic c);
    bitin = b;
    bit_valid = v;
    clear = c;
    @(posedge clock);
    model_edge();
    #1;
    check_all("cyc");
  endtask

  task automatic run_seq(input logic [6:0] s, input logic [6:0] e,
                         input int gap, output int pulses);
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      cyc(s[6-i], 1'b1, 1'b0);
      pulses += int'(pulse8);
      chk("seq_ind", 32'(ind8), 32'(e[6-i]));
      for (int j = 0; j < gap; j++) begin
        cyc(1'b0, 1'b0, 1'b0);
        pulses += int'(pulse8);
        chk("gap_ind", 32'(ind8), 32'(e[6-i]));
      end
    end
  endtask

  initial begin
    int pc;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ind", 32'(ind8), 32'd0);
    chk("rst_pulse", 32'(pulse8), 32'd0);
    chk("rst_cnt", 32'(cnt8), 32'd0);
    reset = 1'b0;

    // reset mid-stream
    pattern = '0; pat_len = 4'd3; overlap = 1'b1;
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("pre_rst_ind", 32'(ind8), 32'd1);
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_ind", 32'(ind8), 32'd0);
    chk("mid_rst_pulse", 32'(pulse8), 32'd0);
    chk("mid_rst_cnt", 32'(cnt8), 32'd0);
    model_reset();
    #1 reset = 1'b0;
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("post_rst_2", 32'(ind8), 32'd0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("post_rst_3", 32'(ind8), 32'd1);

    // legacy overlapping
    cyc(1'b0, 1'b0, 1'b1);
    run_seq(7'b1000001, 7'b0001110, 0, pc);
    chk("legacy_pulses", 32'(pc), 32'd3);
    chk("legacy_cnt", 32'(cnt8), 32'd3);

    // non-overlapping
    overlap = 1'b0;
    cyc(1'b0, 1'b0, 1'b1);
    run_seq(7'b1000001, 7'b0001000, 0, pc);
    chk("nonov_pulses", 32'(pc), 32'd1);
    chk("nonov_cnt", 32'(cnt8), 32'd1);

    // arbitrary pattern
    overlap = 1'b1; pattern = 8'b0000_1011; pat_len = 4'd4;
    cyc(1'b0, 1'b0, 1'b1);
    run_seq(7'b1011011, 7'b0001001, 0, pc);
    chk("pat_pulses", 32'(pc), 32'd2);
    chk("pat_cnt", 32'(cnt8), 32'd2);

    // valid gaps
    pattern = '0; pat_len = 4'd3;
    cyc(1'b0, 1'b0, 1'b1);
    run_seq(7'b1000001, 7'b0001110, 3, pc);
    chk("gap_pulses", 32'(pc), 32'd3);
    chk("gap_cnt", 32'(cnt8), 32'd3);

    // saturation, clear with valid, bad length
    pat_len = 4'd1;
    cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0);
    chk("sat_cnt2", 32'(cnt2), 32'd3);
    chk("sat_cnt8", 32'(cnt8), 32'd5);
    chk("sat_pulse", 32'(pulse2), 32'd1);
    cyc(1'b0, 1'b1, 1'b1);
    chk("clr_ind", 32'(ind2), 32'd0);
    chk("clr_pulse", 32'(pulse2), 32'd0);
    chk("clr_cnt", 32'(cnt2), 32'd0);
    pat_len = 4'd0;
    for (int i = 0; i < 40; i++)
      cyc(1'($urandom_range(0, 1)), 1'b1, 1'b0);
    chk("len0_cnt", 32'(cnt8), 32'd0);
    pat_len = 4'd9;
    for (int i = 0; i < 40; i++)
      cyc(1'b0, 1'b1, 1'b0);
    chk("len9_cnt", 32'(cnt8), 32'd0);

    // random stream
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        pattern = ML'($urandom);
        overlap = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) != 0)
          pat_len = 4'($urandom_range(1, 4));
        else
          pat_len = 4'($urandom_range(0, 15));
      end
      cyc(1'($urandom_range(0, 1)),
          1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 199) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
